// File: rtl/pmsm_pkg.sv
// Shared constants for the three-phase PWM generator: default widths,
// phase indices and carrier direction encoding.
package pmsm_pkg;

  localparam int unsigned CNT_W_DEF = 16;
  localparam int unsigned DT_W_DEF  = 8;

  localparam int unsigned NUM_PH = 3;
  localparam int unsigned PH_A   = 0;
  localparam int unsigned PH_B   = 1;
  localparam int unsigned PH_C   = 2;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

endpackage

// File: rtl/pmsm_deadtime.sv
// Per-phase dead-time stage: turns a raw compare into a complementary hi/lo
// gate pair, holding both low for 'deadtime' cycles after every raw edge.
module pmsm_deadtime #(
  parameter int unsigned DT_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            raw,
  input  logic [DT_W-1:0] deadtime,
  output logic            hi,
  output logic            lo
);

  logic            raw_prev_q, raw_prev_d;
  logic [DT_W-1:0] dtcnt_q, dtcnt_d;
  logic            hi_q, hi_d;
  logic            lo_q, lo_d;

  // An edge (re)starts the blanking window; the selected side asserts on the
  // cycle the counter reaches zero, or immediately when deadtime is zero.
  always_comb begin
    raw_prev_d = raw;
    dtcnt_d    = dtcnt_q;
    hi_d       = 1'b0;
    lo_d       = 1'b0;
    if (raw != raw_prev_q) begin
      dtcnt_d = deadtime;
      if (deadtime == '0) begin
        hi_d = raw;
        lo_d = !raw;
      end
    end else if (dtcnt_q != '0) begin
      dtcnt_d = dtcnt_q - DT_W'(1);
      if (dtcnt_q == DT_W'(1)) begin
        hi_d = raw;
        lo_d = !raw;
      end
    end else begin
      hi_d = raw;
      lo_d = !raw;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      raw_prev_q <= 1'b0;
      dtcnt_q    <= '0;
      hi_q       <= 1'b0;
      lo_q       <= 1'b0;
    end else begin
      raw_prev_q <= raw_prev_d;
      dtcnt_q    <= dtcnt_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: rtl/pmsm_pwm3_gen.sv
// Three-phase centre-aligned PWM with staged/shadowed settings that switch
// only at the carrier valley, feeding three dead-time stages.
module pmsm_pwm3_gen
  import pmsm_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned DT_W  = DT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] duty_a,
  input  logic [CNT_W-1:0] duty_b,
  input  logic [CNT_W-1:0] duty_c,
  input  logic [DT_W-1:0]  deadtime,
  output logic [2:0]       phase_hi,
  output logic [2:0]       phase_lo,
  output logic             period_sync,
  output logic             load_ack
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  dir_e             dir_q, dir_d;

  logic [CNT_W-1:0]             stg_period_q, stg_period_d;
  logic [NUM_PH-1:0][CNT_W-1:0] stg_duty_q, stg_duty_d;
  logic [DT_W-1:0]              stg_dt_q, stg_dt_d;
  logic                         pend_q, pend_d;

  logic [CNT_W-1:0]             shd_period_q, shd_period_d;
  logic [NUM_PH-1:0][CNT_W-1:0] shd_duty_q, shd_duty_d;
  logic [DT_W-1:0]              shd_dt_q, shd_dt_d;

  logic sync_q, sync_d;
  logic ack_q, ack_d;

  logic                         valley_c;
  logic                         upd_c;
  logic                         run_c;
  logic [NUM_PH-1:0][CNT_W-1:0] duty_in_c;
  logic [NUM_PH-1:0]            raw_c;

  always_comb begin
    duty_in_c       = '0;
    duty_in_c[PH_A] = duty_a;
    duty_in_c[PH_B] = duty_b;
    duty_in_c[PH_C] = duty_c;
  end

  // A load landing on the valley wins over the pending transfer, so the
  // shadows keep their values for one more carrier.
  always_comb begin
    valley_c     = en && (cnt_q == '0);
    upd_c        = valley_c && pend_q && !load;
    stg_period_d = stg_period_q;
    stg_duty_d   = stg_duty_q;
    stg_dt_d     = stg_dt_q;
    pend_d       = pend_q;
    shd_period_d = shd_period_q;
    shd_duty_d   = shd_duty_q;
    shd_dt_d     = shd_dt_q;
    if (load) begin
      stg_period_d = period;
      stg_duty_d   = duty_in_c;
      stg_dt_d     = deadtime;
      pend_d       = 1'b1;
    end else if (upd_c) begin
      pend_d = 1'b0;
    end
    if (upd_c) begin
      shd_period_d = stg_period_q;
      shd_duty_d   = stg_duty_q;
      shd_dt_d     = stg_dt_q;
    end
  end

  // The valley cycle already belongs to the new carrier, so it runs on the
  // settings being transferred in that cycle.
  assign run_c = en && (shd_period_d >= CNT_W'(2));

  always_comb begin
    cnt_d = '0;
    dir_d = DIR_UP;
    if (run_c) begin
      if (dir_q == DIR_UP) begin
        if (cnt_q == shd_period_d - CNT_W'(1)) begin
          cnt_d = shd_period_d;
          dir_d = DIR_DOWN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else begin
        dir_d = DIR_DOWN;
        if (cnt_q == CNT_W'(1)) begin
          cnt_d = '0;
          dir_d = DIR_UP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
    end
  end

  // Strict compare going up, inclusive going down: exactly 2*D high cycles.
  always_comb begin
    raw_c = '0;
    for (int unsigned i = 0; i < NUM_PH; i++) begin
      if (run_c) begin
        raw_c[i] = (dir_q == DIR_UP) ? (cnt_q < shd_duty_d[i])
                                     : (cnt_q <= shd_duty_d[i]);
      end
    end
  end

  always_comb begin
    sync_d = (valley_c && run_c) || upd_c;
    ack_d  = upd_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      dir_q        <= DIR_UP;
      stg_period_q <= '0;
      stg_duty_q   <= '0;
      stg_dt_q     <= '0;
      pend_q       <= 1'b0;
      shd_period_q <= '0;
      shd_duty_q   <= '0;
      shd_dt_q     <= '0;
      sync_q       <= 1'b0;
      ack_q        <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      dir_q        <= dir_d;
      stg_period_q <= stg_period_d;
      stg_duty_q   <= stg_duty_d;
      stg_dt_q     <= stg_dt_d;
      pend_q       <= pend_d;
      shd_period_q <= shd_period_d;
      shd_duty_q   <= shd_duty_d;
      shd_dt_q     <= shd_dt_d;
      sync_q       <= sync_d;
      ack_q        <= ack_d;
    end
  end

  for (genvar g = 0; g < NUM_PH; g++) begin : g_dt
    pmsm_deadtime #(
      .DT_W(DT_W)
    ) u_dt (
      .clk      (clk),
      .rst      (rst),
      .raw      (raw_c[g]),
      .deadtime (shd_dt_d),
      .hi       (phase_hi[g]),
      .lo       (phase_lo[g])
    );
  end

  assign period_sync = sync_q;
  assign load_ack    = ack_q;

endmodule
